// File: rtl/led_scan_rx_pkg.sv
// led_scan_rx_pkg: shared constants and types for the seven-segment scan receiver.
//   - segment / digit-enable polarity and idle values
//   - 16-entry glyph table (index = hex nibble, value = active-low {dp,g..a})
//   - FSM state encoding
//   - small helpers for classifying a digit-enable byte
package led_scan_rx_pkg;

    localparam int         NUM_DIG   = 4;
    localparam logic       SEG_ON    = 1'b0;   // segments and enables are active-low
    localparam logic       SEG_OFF   = 1'b1;
    localparam logic [7:0] DE_NONE   = 8'hFF;  // no digit selected
    localparam logic [7:0] SEG_BLANK = 8'hFF;  // all segments dark

    // Entry i is the pattern for nibble i, dp off. Only bits [6:0] are compared.
    localparam logic [15:0][7:0] GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_e;

    // One sample of the bus: digit enables plus segment byte.
    typedef struct packed {
        logic [7:0] de;
        logic [7:0] led;
    } scan_t;

    // Number of asserted (low) enables.
    function automatic logic [3:0] de_zeros(input logic [7:0] de);
        de_zeros = '0;
        for (int i = 0; i < 8; i++)
            if (de[i] == SEG_ON) de_zeros = de_zeros + 4'd1;
    endfunction

    // Position of the low bit in the lower nibble; only meaningful when exactly one is low.
    function automatic logic [1:0] de_idx(input logic [3:0] de_lo);
        de_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (de_lo[i] == SEG_ON) de_idx = 2'(i);
    endfunction

endpackage

// File: rtl/led_scan_rx_if.sv
// led_scan_rx_if: scan bus in, captured display state out.
//   de, ledout        : raw multiplexed scan (driven by the display side / bench)
//   digit_seg         : {d3,d2,d1,d0} captured segment bytes
//   frame_vld         : one-cycle pulse per complete four-digit frame
//   stall, err_multi  : timeout level / sticky multi-enable error
//   hex, hex_vld      : decoded nibbles and glyph-legal flags (zero unless decode is built)
// modport master: the scan source and consumer of the captured state.
// modport slave : the receiver (led_scan_rx).
interface led_scan_rx_if;
    logic [7:0]  de;
    logic [7:0]  ledout;
    logic [31:0] digit_seg;
    logic        frame_vld;
    logic        stall;
    logic        err_multi;
    logic [15:0] hex;
    logic [3:0]  hex_vld;

    modport master (
        output de, ledout,
        input  digit_seg, frame_vld, stall, err_multi, hex, hex_vld
    );

    modport slave (
        input  de, ledout,
        output digit_seg, frame_vld, stall, err_multi, hex, hex_vld
    );
endinterface

// File: rtl/led_scan_rx_seg7_to_hex.sv
// seg7_to_hex: combinational glyph decoder, active-low {g..a} -> {vld, nibble}.
//   seg_i [6:0] : segment pattern (dp excluded)
//   vld_o       : pattern is one of the 16 hex glyphs
//   nib_o [3:0] : decoded nibble, 0 when not a glyph
// Only compiled when SEG_DECODE_EN is defined; without it no decode logic exists.
`ifdef SEG_DECODE_EN
module seg7_to_hex
    import led_scan_rx_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       vld_o,
    output logic [3:0] nib_o
);
    always_comb begin
        vld_o = 1'b0;
        nib_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == GLYPH[i][6:0]) begin
                vld_o = 1'b1;
                nib_o = 4'(i);
            end
        end
    end
endmodule
`endif

// File: rtl/led_scan_rx.sv
// led_scan_rx: receiver for a 4-digit multiplexed seven-segment scan bus.
// Synchronizes de/ledout, waits for STABLE_CYC identical samples, then commits the
// segment byte of the selected digit into a holding register.
// Ports:
//   clk    : system clock
//   clr_n  : asynchronous active-low reset
//   bus    : led_scan_rx_if.slave (de/ledout in; digit_seg, frame_vld, stall,
//            err_multi, hex, hex_vld out)
// Parameters:
//   STABLE_CYC  : consecutive identical samples before a commit (>=1)
//   TIMEOUT_CYC : clocks without a digit write before stall asserts
// Build option: SEG_DECODE_EN adds per-digit glyph decode onto hex/hex_vld;
//   otherwise those outputs are tied to zero.
module led_scan_rx
    import led_scan_rx_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic         clk,
    input  logic         clr_n,
    led_scan_rx_if.slave bus
);
    localparam int CW  = $clog2(STABLE_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    // cnt value from which the next unchanged sample completes the stable run
    localparam int CMT = (STABLE_CYC > 1) ? STABLE_CYC - 2 : 0;

    scan_t                    s1_q, s2_q, prev_q;
    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic                     p_chg, commit, wr_en, err_set;
    logic [3:0]               zeros;
    logic [1:0]               idx;
    logic [NUM_DIG-1:0][7:0]  seg_q, seg_d;
    logic [NUM_DIG-1:0]       seen_q, seen_d;
    logic                     frame_q, stall_q, stall_d, err_q;
    logic [TW-1:0]            to_q, to_d;

    // Two-flop synchronizer; reset to an idle bus so a quiet bus never looks like a change.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_q <= {DE_NONE, SEG_BLANK};
            s2_q <= {DE_NONE, SEG_BLANK};
        end else begin
            s1_q <= {bus.de, bus.ledout};
            s2_q <= s1_q;
        end
    end

    assign p_chg = (s2_q != prev_q);

    // The first sample of a new pattern is counted on the change cycle itself, so with
    // STABLE_CYC==1 the change cycle is also the commit cycle.
    always_comb begin
        commit = 1'b0;
        if (p_chg)
            commit = (STABLE_CYC == 1);
        else if (state_q == ST_SETTLE)
            commit = (cnt_q == CW'(CMT));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prev_q  <= {DE_NONE, SEG_BLANK};
        end else begin
            prev_q <= s2_q;
            if (p_chg) begin
                cnt_q   <= '0;
                state_q <= commit ? ST_HELD : ST_SETTLE;
            end else if (state_q == ST_SETTLE) begin
                cnt_q <= cnt_q + 1'b1;
                if (commit) state_q <= ST_HELD;
            end
        end
    end

    // Classify the committed enable byte: one low bit in [3:0] writes a digit,
    // idle or a digit 4/5 select is ignored, several low bits flag an error.
    always_comb begin
        zeros   = de_zeros(s2_q.de);
        idx     = de_idx(s2_q.de[3:0]);
        wr_en   = commit && (zeros == 4'd1) && (s2_q.de[7:4] == 4'hF);
        err_set = commit && (zeros > 4'd1);
    end

    always_comb begin
        seg_d = seg_q;
        if (wr_en) seg_d[idx] = s2_q.led;
    end

    // A completed frame empties seen before this cycle's write lands, so a write on the
    // frame cycle starts the next frame. A write also beats a simultaneous timeout.
    always_comb begin
        seen_d  = (seen_q == 4'hF) ? '0 : seen_q;
        to_d    = to_q;
        stall_d = stall_q;
        if (wr_en) begin
            seen_d[idx] = 1'b1;
            to_d        = '0;
            stall_d     = 1'b0;
        end else if (to_q != TW'(TIMEOUT_CYC)) begin
            to_d = to_q + 1'b1;
            if (to_d == TW'(TIMEOUT_CYC)) begin
                stall_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seg_q   <= {NUM_DIG{SEG_BLANK}};
            seen_q  <= '0;
            frame_q <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            seg_q   <= seg_d;
            seen_q  <= seen_d;
            frame_q <= (seen_q == 4'hF);
            stall_q <= stall_d;
            to_q    <= to_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus.digit_seg = seg_q;
    assign bus.frame_vld = frame_q;
    assign bus.stall     = stall_q;
    assign bus.err_multi = err_q;

`ifdef SEG_DECODE_EN
    logic [NUM_DIG-1:0][3:0] nib, hex_q;
    logic [NUM_DIG-1:0]      nib_vld, hv_q;

    // Each lane decodes its own next-state byte, so hex lines up with digit_seg and
    // only moves when that digit is written.
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
        seg7_to_hex u_dec (
            .seg_i (seg_d[g][6:0]),
            .vld_o (nib_vld[g]),
            .nib_o (nib[g])
        );
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hex_q <= '0;
            hv_q  <= '0;
        end else begin
            hex_q <= nib;
            hv_q  <= nib_vld;
        end
    end

    assign bus.hex     = hex_q;
    assign bus.hex_vld = hv_q;
`else
    assign bus.hex     = '0;
    assign bus.hex_vld = '0;
`endif

endmodule
